pe_job_arbiter: RTL
===================

Name: pe_job_arbiter

Overview:
- Round-robin scheduler that shares a single metronome_signed PE datapath between NREQ requesters.
- Grants one requester at a time and drives the metronome's device_in_valid for exactly LEN accepted input beats.
- Waits for LEN output beats to drain, pulses a per-requester done, then re-arbitrates.
- Sits between the host-side job sources and the metronome/PE row.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN, 16, input beats per job; matches the metronome depth parameter.
- CW, 7, beat-counter width; must satisfy 2^CW > LEN.
- TIMEOUT, 255, idle cycles allowed in DRAIN without data_out_valid before the job is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester job request, level.
- gnt  out  NREQ  one-hot grant, held for the whole job.
- owner  out  3  index of the current grantee; valid while busy.
- busy  out  1  high from grant through DONE.
- done  out  NREQ  one-cycle pulse on the owner's bit at job end.
- err  out  1  sticky timeout flag, cleared only by reset.
- device_in_valid  out  1  to metronome: job input window open.
- data_in_valid  in  1  from metronome: input beat accepted this cycle.
- data_out_valid  in  1  from metronome: output beat produced this cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE; gnt=0, owner=0, busy=0, done=0, err=0, device_in_valid=0; in/out counters=0; rr pointer=NREQ-1, so the first search starts at requester 0.
- All state is updated on the rising edge of clk. Outputs are registered.
- IDLE:
  - If req is nonzero, select the first asserted bit searching upward from rr+1 with modulo-NREQ wrap.
  - On that edge: latch owner, set gnt one-hot and busy=1, go to FEED.
  - Latency is 1 cycle from req being sampled high to gnt high.
- FEED:
  - device_in_valid=1.
  - Each cycle with data_in_valid=1 increments in_cnt.
  - On the edge where in_cnt reaches LEN: device_in_valid drops, clear the idle timer, go to DRAIN.
  - data_in_valid seen outside FEED is ignored.
- DRAIN:
  - device_in_valid=0.
  - Each data_out_valid=1 increments out_cnt and clears the idle timer; otherwise the timer increments.
  - out_cnt reaching LEN goes to DONE.
  - The timer reaching TIMEOUT sets err=1 and goes to DONE.
  - data_out_valid seen in FEED is also counted toward out_cnt, because the pipeline may overlap.
- DONE (exactly 1 cycle):
  - done[owner]=1.
  - On exit: gnt=0, busy=0, rr=owner, counters cleared, return to IDLE.
  - A new grant can therefore appear no earlier than 2 cycles after the done pulse edge.
- req changes during a job:
  - Deasserting req mid-job does not abort; the job runs to completion.
  - Newly asserted req bits wait for the next IDLE arbitration.
- A requester holding req through DONE is re-eligible, but rotates behind all other pending requesters.
- If owner is the only active request it is regranted: 1 idle cycle between jobs.
- Only one gnt bit is ever high; done and gnt are never nonzero for different indices.
- Counter wrap cannot occur: in_cnt and out_cnt saturate at LEN, and excess data_out_valid beats in DONE/IDLE are ignored.
- Reset mid-job: all outputs return to reset values immediately (async); no done pulse is issued; err clears.

Test Plan:
- Single job: req=4'b0001, metronome model accepts every cycle → gnt=0001 one cycle after req; device_in_valid high for exactly 16 cycles; done[0] pulses once after the 16th data_out_valid; busy low the following cycle.
- Round-robin: req=4'b1111 held, 4 jobs → grant order 0,1,2,3,0; owner values match the order; never two gnt bits high.
- Throttled input: data_in_valid asserted every 3rd cycle → device_in_valid stays high until 16 accepts (about 48 cycles) and no longer.
- Timeout: model stops after 10 outputs → after 255 idle cycles err=1 and done[owner] pulses; the next request is still served; err stays 1.
- req drop mid-job: req[2] deasserted during FEED → job completes with done[2]; a pending req[1] is granted next.
- Async reset: rst=0 in the middle of DRAIN → gnt, busy, device_in_valid and err read 0 before the next clk edge; no done pulse; after rst=1 with req=0010, requester 1 is granted.

Source files
------------

// File: rtl/pe_job_arbiter.sv
// Round-robin job scheduler sharing one metronome PE datapath among NREQ requesters.
// Each grant opens the input window for LEN accepted beats, then waits for LEN output beats or a timeout.
module pe_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int LEN     = 16,
  parameter int CW      = 7,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      owner,
  output logic            busy,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            device_in_valid,
  input  logic            data_in_valid,
  input  logic            data_out_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [2:0]      rr, rr_nxt, owner_nxt, sel;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic            busy_nxt, err_nxt, div_nxt;
  logic            in_step, out_step, in_last, out_full, timer_hit;

  // Beat strobes are single-cycle qualifiers from the metronome: data_in_valid means
  // one input beat was accepted while device_in_valid was high, data_out_valid means one
  // result beat left the pipeline. There is no backpressure in either direction.
  assign in_step   = (state == FEED) && data_in_valid && (in_cnt != LEN_C);
  assign out_step  = ((state == FEED) || (state == DRAIN)) && data_out_valid && (out_cnt != LEN_C);
  assign in_last   = in_step && (in_cnt == LEN_C - 1'b1);
  assign out_full  = (out_cnt == LEN_C) || (out_step && (out_cnt == LEN_C - 1'b1));
  assign timer_hit = !data_out_valid && (timer == TIMEOUT_LAST);

  // Lowest requester above rr wins; if none, wrap to the lowest requester overall.
  always_comb begin
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) sel = 3'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) > rr)) sel = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      gnt             <= '0;
      owner           <= '0;
      busy            <= 1'b0;
      done            <= '0;
      err             <= 1'b0;
      device_in_valid <= 1'b0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      timer           <= '0;
      rr              <= 3'(NREQ - 1);
    end else begin
      state           <= state_nxt;
      gnt             <= gnt_nxt;
      owner           <= owner_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      err             <= err_nxt;
      device_in_valid <= div_nxt;
      in_cnt          <= in_cnt_nxt;
      out_cnt         <= out_cnt_nxt;
      timer           <= timer_nxt;
      rr              <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = FEED;
      FEED:    if (in_last) state_nxt = DRAIN;
      DRAIN:   if (out_full || timer_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt     = gnt;
    owner_nxt   = owner;
    busy_nxt    = busy;
    done_nxt    = '0;
    err_nxt     = err;
    div_nxt     = device_in_valid;
    rr_nxt      = rr;
    in_cnt_nxt  = in_cnt + CW'(in_step);
    out_cnt_nxt = out_cnt + CW'(out_step);
    timer_nxt   = timer;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt = sel;
          gnt_nxt   = NREQ'(1) << sel;
          busy_nxt  = 1'b1;
          div_nxt   = 1'b1;
        end
      end
      FEED: begin
        if (in_last) begin
          div_nxt   = 1'b0;
          timer_nxt = '0;
        end
      end
      DRAIN: begin
        timer_nxt = data_out_valid ? '0 : timer + 1'b1;
        if (state_nxt == DONE) begin
          done_nxt = gnt;
          // A drain that ends without all outputs is an abort by timeout.
          if (!out_full) err_nxt = 1'b1;
        end
      end
      DONE: begin
        gnt_nxt     = '0;
        busy_nxt    = 1'b0;
        rr_nxt      = owner;
        in_cnt_nxt  = '0;
        out_cnt_nxt = '0;
        timer_nxt   = '0;
      end
      default: ;
    endcase
  end

endmodule
